// File: rtl/hazard_sched_if.sv
// D-stage hazard bundle: decode-side operand/destination info in, stall and bypass selects out.
interface hazard_sched_if;
    logic [4:0] D_GRF_A1;
    logic [4:0] D_GRF_A2;
    logic [1:0] D_tuse_rs;
    logic [1:0] D_tuse_rt;
    logic       D_GRF_WE;
    logic [4:0] D_GRF_A3;
    logic [1:0] D_tnew;
    logic       D_md_flag;
    logic       D_md_start;
    logic       D_md_div;
    logic       flush;
    logic       stall;
    logic [2:0] D_GRF_RD1_FWD;
    logic [2:0] D_GRF_RD2_FWD;
    logic       md_busy;

    modport master (
        output D_GRF_A1, D_GRF_A2, D_tuse_rs, D_tuse_rt, D_GRF_WE, D_GRF_A3, D_tnew,
               D_md_flag, D_md_start, D_md_div, flush,
        input  stall, D_GRF_RD1_FWD, D_GRF_RD2_FWD, md_busy
    );

    modport slave (
        input  D_GRF_A1, D_GRF_A2, D_tuse_rs, D_tuse_rt, D_GRF_WE, D_GRF_A3, D_tnew,
               D_md_flag, D_md_start, D_md_div, flush,
        output stall, D_GRF_RD1_FWD, D_GRF_RD2_FWD, md_busy
    );
endinterface

// File: rtl/hazard_sched.sv
// Tuse/Tnew hazard scheduler for the D stage: E/M scoreboard, stall and bypass selects.
// Define HCU_MDU_EN to add multiply/divide busy tracking; otherwise md_busy is tied low.
module hazard_sched (
    input  logic          clk,
    input  logic          reset,
    hazard_sched_if.slave hz
);
    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    logic       we_p0, we_p1;
    logic [4:0] a3_p0, a3_p1;
    logic [1:0] tnew_p0, tnew_p1;

    logic       stall, stall_hz, stall_md, md_busy;
    logic       rs_e, rs_m, rt_e, rt_m;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_match(input logic [4:0] a, input logic we, input logic [4:0] a3);
        return (a != 5'd0) && we && (a3 == a);
    endfunction

    function automatic logic [2:0] fwd_sel(input logic hit_e, input logic [1:0] t_e,
                                           input logic hit_m, input logic [1:0] t_m);
        if (hit_e && t_e == 2'd0) return 3'd1;
        if (hit_m && t_m == 2'd0) return 3'd2;
        return 3'd0;
    endfunction

    always_comb begin
        rs_e = src_match(hz.D_GRF_A1, we_p0, a3_p0);
        rs_m = src_match(hz.D_GRF_A1, we_p1, a3_p1);
        rt_e = src_match(hz.D_GRF_A2, we_p0, a3_p0);
        rt_m = src_match(hz.D_GRF_A2, we_p1, a3_p1);
        stall_hz = (rs_e && tnew_p0 > hz.D_tuse_rs) || (rs_m && tnew_p1 > hz.D_tuse_rs) ||
                   (rt_e && tnew_p0 > hz.D_tuse_rt) || (rt_m && tnew_p1 > hz.D_tuse_rt);
    end

    assign stall            = stall_hz || stall_md;
    assign hz.stall         = stall;
    assign hz.D_GRF_RD1_FWD = fwd_sel(rs_e, tnew_p0, rs_m, tnew_p1);
    assign hz.D_GRF_RD2_FWD = fwd_sel(rt_e, tnew_p0, rt_m, tnew_p1);
    assign hz.md_busy       = md_busy;

    // D -> E (_p0) -> M (_p1); a stalled D injects a bubble, flush empties both stages
    always_ff @(posedge clk) begin
        if (reset || hz.flush) begin
            we_p0   <= 1'b0;
            a3_p0   <= 5'd0;
            tnew_p0 <= 2'd0;
            we_p1   <= 1'b0;
            a3_p1   <= 5'd0;
            tnew_p1 <= 2'd0;
        end else begin
            we_p0   <= stall ? 1'b0 : hz.D_GRF_WE;
            a3_p0   <= stall ? 5'd0 : hz.D_GRF_A3;
            tnew_p0 <= stall ? 2'd0 : hz.D_tnew;
            we_p1   <= we_p0;
            a3_p1   <= a3_p0;
            tnew_p1 <= sat_dec(tnew_p0);
        end
    end

`ifdef HCU_MDU_EN
    logic       md_pend;
    logic       md_div;
    logic [3:0] md_cnt;
    logic       md_issue;

    assign md_issue = hz.D_md_start && !stall && !hz.flush;

    // Pending marks the op sitting in E; a flushed op never loads the counter,
    // while an op already counting runs to completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_pend <= 1'b0;
            md_div  <= 1'b0;
            md_cnt  <= 4'd0;
        end else begin
            md_pend <= md_issue;
            if (md_issue) md_div <= hz.D_md_div;
            if (md_pend && !hz.flush) md_cnt <= md_div ? DIV_LAT : MUL_LAT;
            else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy  = md_pend || (md_cnt != 4'd0);
    assign stall_md = hz.D_md_flag && md_busy;
`else
    logic unused_md;
    assign unused_md = ^{hz.D_md_flag, hz.D_md_start, hz.D_md_div, MUL_LAT, DIV_LAT};
    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: instruction-history model checked every cycle plus literal checks.
module tb_hazard_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_sched_if hz();
    hazard_sched dut (.clk(clk), .reset(reset), .hz(hz));

`ifdef HCU_MDU_EN
    localparam int MD_ON = 1, DIV_CYC = 11, MUL_CYC = 6;
`else
    localparam int MD_ON = 0, DIV_CYC = 0, MUL_CYC = 0;
`endif

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       we;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       mdf;
        logic       mds;
        logic       mdd;
    } instr_t;

    int checks = 0;
    int errors = 0;

    // Model: the instructions that left D one and two cycles ago, with their original tnew.
    instr_t pipe_q[2];
    int     t_cyc = 0;
    int     busy_until = 0;
    int     prev_until = 0;
    bit     just_issued = 0;
    bit     model_live = 0;

    function automatic instr_t mk(input int a1, input int a2, input int trs, input int trt,
                                  input int we, input int a3, input int tnew,
                                  input int mdf = 0, input int mds = 0, input int mdd = 0);
        instr_t i;
        i.a1 = 5'(a1); i.a2 = 5'(a2); i.tuse_rs = 2'(trs); i.tuse_rt = 2'(trt);
        i.we = 1'(we); i.a3 = 5'(a3); i.tnew = 2'(tnew);
        i.mdf = 1'(mdf); i.mds = 1'(mds); i.mdd = 1'(mdd);
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 3, 3, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_eval(output logic st, output int f1, output int f2, output logic busy);
        int src[2];
        int tu[2];
        int fw[2];
        int r;
        src[0] = int'(hz.D_GRF_A1); tu[0] = int'(hz.D_tuse_rs);
        src[1] = int'(hz.D_GRF_A2); tu[1] = int'(hz.D_tuse_rt);
        st = 1'b0;
        for (int o = 0; o < 2; o++) begin
            fw[o] = 0;
            for (int k = 0; k < 2; k++) begin
                r = int'(pipe_q[k].tnew) - k;
                if (r < 0) r = 0;
                if (pipe_q[k].we && src[o] != 0 && int'(pipe_q[k].a3) == src[o]) begin
                    if (r > tu[o]) st = 1'b1;
                    if (r == 0 && fw[o] == 0) fw[o] = k + 1;
                end
            end
        end
        f1 = fw[0];
        f2 = fw[1];
`ifdef HCU_MDU_EN
        busy = (t_cyc < busy_until);
`else
        busy = 1'b0;
`endif
        if (hz.D_md_flag && busy) st = 1'b1;
    endfunction

    always @(posedge clk) begin
        logic st, busy;
        int f1, f2;
        instr_t d;
        model_eval(st, f1, f2, busy);
        d = mk(hz.D_GRF_A1, hz.D_GRF_A2, hz.D_tuse_rs, hz.D_tuse_rt, hz.D_GRF_WE,
               hz.D_GRF_A3, hz.D_tnew, hz.D_md_flag, hz.D_md_start, hz.D_md_div);
        t_cyc++;
        if (reset) begin
            pipe_q[0] = '0;
            pipe_q[1] = '0;
            busy_until = 0;
            prev_until = 0;
            just_issued = 0;
            model_live = 1;
        end else if (hz.flush) begin
            pipe_q[0] = '0;
            pipe_q[1] = '0;
            if (just_issued) busy_until = prev_until;
            just_issued = 0;
        end else begin
            pipe_q[1] = pipe_q[0];
            pipe_q[0] = st ? '0 : d;
            just_issued = 0;
            if (d.mds && !st) begin
                prev_until = busy_until;
                busy_until = t_cyc + (d.mdd ? 10 : 5) + 1;
                just_issued = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic st, busy;
        int f1, f2;
        if (model_live) begin
            model_eval(st, f1, f2, busy);
            chk("model_stall", int'(hz.stall), int'(st));
            chk("model_rd1_fwd", int'(hz.D_GRF_RD1_FWD), f1);
            chk("model_rd2_fwd", int'(hz.D_GRF_RD2_FWD), f2);
            chk("model_md_busy", int'(hz.md_busy), int'(busy));
        end
    end

    task automatic step(input instr_t i, input logic fl = 1'b0);
        hz.D_GRF_A1 = i.a1; hz.D_GRF_A2 = i.a2;
        hz.D_tuse_rs = i.tuse_rs; hz.D_tuse_rt = i.tuse_rt;
        hz.D_GRF_WE = i.we; hz.D_GRF_A3 = i.a3; hz.D_tnew = i.tnew;
        hz.D_md_flag = i.mdf; hz.D_md_start = i.mds; hz.D_md_div = i.mdd;
        hz.flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t lw3, add3, mul, dv, mfhi;
        int n;
        reset = 1'b1;
        step(nop());
        tick(); tick();
        reset = 1'b0;
        step(nop());
        chk("reset_stall", int'(hz.stall), 0);
        chk("reset_fwd1", int'(hz.D_GRF_RD1_FWD), 0);
        chk("reset_fwd2", int'(hz.D_GRF_RD2_FWD), 0);
        chk("reset_busy", int'(hz.md_busy), 0);

        // load-use: lw $3 ; add $4,$3,$5
        lw3  = mk(0, 0, 3, 3, 1, 3, 2);
        add3 = mk(3, 5, 1, 1, 1, 4, 1);
        step(lw3); tick();
        step(add3);
        chk("lw_use_stall", int'(hz.stall), 1);
        tick();
        step(add3);
        chk("lw_use_release", int'(hz.stall), 0);
        tick();

        // ALU result into a tuse=0 branch
        step(mk(0, 0, 3, 3, 1, 3, 1)); tick();
        step(mk(3, 0, 0, 0, 0, 0, 0));
        chk("beq_stall", int'(hz.stall), 1);
        tick();
        step(mk(3, 0, 0, 0, 0, 0, 0));
        chk("beq_release", int'(hz.stall), 0);
        chk("beq_fwd_m", int'(hz.D_GRF_RD1_FWD), 2);
        tick();

        // rt operand from M after an unrelated instruction
        step(mk(0, 0, 3, 3, 1, 7, 1)); tick();
        step(nop()); tick();
        step(mk(0, 7, 3, 2, 0, 0, 0));
        chk("rt_fwd_m", int'(hz.D_GRF_RD2_FWD), 2);
        chk("rt_no_stall", int'(hz.stall), 0);
        tick();

        // jal $31 ; jr $31
        step(mk(0, 0, 3, 3, 1, 31, 0)); tick();
        step(mk(31, 0, 0, 3, 0, 0, 0));
        chk("jr_stall", int'(hz.stall), 0);
        chk("jr_fwd_e", int'(hz.D_GRF_RD1_FWD), 1);
        tick();

        // E wins over M when both hold $31 ready
        step(mk(0, 0, 3, 3, 1, 31, 0)); tick();
        step(mk(0, 0, 3, 3, 1, 31, 0)); tick();
        step(mk(0, 31, 3, 0, 0, 0, 0));
        chk("prio_fwd2", int'(hz.D_GRF_RD2_FWD), 1);
        tick();

        // writes to $0 never create hazards
        step(mk(0, 0, 3, 3, 1, 0, 2)); tick();
        step(mk(0, 0, 0, 0, 0, 0, 0));
        chk("zero_stall", int'(hz.stall), 0);
        chk("zero_fwd1", int'(hz.D_GRF_RD1_FWD), 0);
        tick();

        // div then mfhi
        dv   = mk(8, 9, 0, 0, 0, 0, 0, 1, 1, 1);
        mul  = mk(8, 9, 0, 0, 0, 0, 0, 1, 1, 0);
        mfhi = mk(0, 0, 3, 3, 1, 10, 1, 1, 0, 0);
        step(dv); tick();
        step(mfhi);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!hz.stall) break;
            n++;
            tick();
        end
        chk("div_stall_cycles", n, DIV_CYC);
        tick();
        step(nop()); tick();

        step(mul); tick();
        step(mfhi);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!hz.md_busy) break;
            n++;
            tick();
        end
        chk("mul_busy_cycles", n, MUL_CYC);
        tick();
        step(nop()); tick();

        // flush while lw in E and dependent in D, with a multiply counting
        step(mul); tick();
        step(lw3); tick();
        step(add3, 1'b1);
        chk("flush_pre_stall", int'(hz.stall), 1);
        tick();
        step(add3);
        chk("flush_post_stall", int'(hz.stall), 0);
        chk("flush_post_fwd1", int'(hz.D_GRF_RD1_FWD), 0);
        chk("flush_busy_kept", int'(hz.md_busy), MD_ON);
        tick();
        for (int k = 0; k < 8; k++) begin
            step(nop()); tick();
        end

        // reset in the middle of a divide (counter at 7)
        step(dv); tick();
        step(mfhi);
        for (int k = 0; k < 4; k++) tick();
        chk("mid_div_busy", int'(hz.md_busy), MD_ON);
        chk("mid_div_stall", int'(hz.stall), MD_ON);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_busy", int'(hz.md_busy), 0);
        chk("post_reset_stall", int'(hz.stall), 0);
        tick();
        step(nop()); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
